// File: rtl/sprite_bitmap_store.sv
// -----------------------------------------------------------------------------
// sprite_bitmap_store
//
// Double-buffered 16x16 sprite bitmap memory. Acts as the responder for the
// sprite renderer's ROM fetch port (rom_addr -> rom_bits). A host or loader
// streams ROWS rows into the back bank. The banks swap only at a frame
// boundary while the renderer is idle, so a scan never shows a torn sprite.
//
// Optional feature (compile-time macro SPRITE_STORE_CLEAR_EN):
//   adds input 'clear'. A clear request in FILL zeroes the whole back bank,
//   one row per cycle, and then queues that blank sprite for swapping.
//
// Parameters
//   DATA_W  bits per sprite row (pixel i = bit i)
//   ADDR_W  row address width, ROWS = 2**ADDR_W
//
// Ports
//   clk          in   pixel clock
//   reset        in   synchronous, active-high
//   wr_valid     in   wr_data holds the next row
//   wr_ready     out  store accepts a row this cycle
//   wr_data      in   row bits; row index is implicit (auto-increment)
//   frame_start  in   1-cycle pulse at the frame boundary
//   rd_busy      in   renderer in progress; swap is blocked while high
//   clear        in   (SPRITE_STORE_CLEAR_EN only) blank the back bank
//   rom_addr     in   renderer row select
//   rom_bits     out  front-bank row, combinational from rom_addr
//   bank_sel     out  index of the current front bank
//   swap_pending out  back bank full, swap not yet done
//   state_dbg    out  current FSM state (FILL=0, PENDING=1, CLEAR=2)
//
// Write handshake: a row transfers on a rising clk edge where
// wr_valid && wr_ready. wr_ready depends only on the FSM state, never on
// wr_valid. While wr_ready is low the source must hold wr_valid/wr_data;
// nothing is written.
// -----------------------------------------------------------------------------
module sprite_bitmap_store #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              frame_start,
  input  logic              rd_busy,
`ifdef SPRITE_STORE_CLEAR_EN
  input  logic              clear,
`endif
  input  logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_bits,
  output logic              bank_sel,
  output logic              swap_pending,
  output logic [1:0]        state_dbg
);

  localparam int ROWS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ROW = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ROW_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLEAR   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] wr_row_q;
  logic              swap_armed_q;
  logic              bank_sel_q;

  // Control decoded from the state (Moore outputs plus qualified strobes).
  logic              row_we;
  logic [DATA_W-1:0] row_wdata;
  logic              do_swap;
  logic              arm;
  logic              clear_req;

  // Two banks; bank[bank_sel_q] is the front (read) bank, the other is the
  // back (write) bank. The front bank is never written.
  logic [DATA_W-1:0] mem [2][ROWS];

`ifdef SPRITE_STORE_CLEAR_EN
  assign clear_req = clear;
`else
  assign clear_req = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        // clear wins over a simultaneous row write.
        if (clear_req) begin
          state_d = ST_CLEAR;
        end else if (wr_valid && (wr_row_q == LAST_ROW)) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // Only an already-armed swap can fire; a frame_start seen in this
        // cycle arms for the next one.
        if (swap_armed_q && !rd_busy) begin
          state_d = ST_FILL;
        end
      end
      ST_CLEAR: begin
        if (wr_row_q == LAST_ROW) begin
          state_d = ST_PENDING;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ready     = 1'b0;
    swap_pending = 1'b0;
    row_we       = 1'b0;
    row_wdata    = '0;
    do_swap      = 1'b0;
    arm          = 1'b0;
    case (state_q)
      ST_FILL: begin
        wr_ready  = 1'b1;
        row_we    = wr_valid && !clear_req;
        row_wdata = wr_data;
      end
      ST_PENDING: begin
        swap_pending = 1'b1;
        do_swap      = swap_armed_q && !rd_busy;
        arm          = frame_start;
      end
      ST_CLEAR: begin
        row_we    = 1'b1;
        row_wdata = '0;
      end
      default: begin
        wr_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Row pointer, swap arming and front-bank select
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_row_q     <= '0;
      swap_armed_q <= 1'b0;
      bank_sel_q   <= 1'b0;
    end else begin
      // Entering CLEAR restarts the pointer so the sweep covers every row,
      // even if a partial fill had advanced it. The pointer wraps naturally
      // after the last row, leaving it at 0 for the next fill.
      if ((state_q == ST_FILL) && clear_req) begin
        wr_row_q <= '0;
      end else if (row_we) begin
        wr_row_q <= wr_row_q + ROW_ONE;
      end

      if (do_swap) begin
        bank_sel_q   <= ~bank_sel_q;
        swap_armed_q <= 1'b0;
      end else if (arm) begin
        swap_armed_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bitmap storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else if (row_we) begin
      mem[~bank_sel_q][wr_row_q] <= row_wdata;
    end
  end

  // Zero-latency read: the renderer latches rom_bits the cycle after it
  // drives rom_addr, so no output register here.
  assign rom_bits  = mem[bank_sel_q][rom_addr];
  assign bank_sel  = bank_sel_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sprite_bitmap_store.sv
// -----------------------------------------------------------------------------
// tb_sprite_bitmap_store
//
// Self-checking bench for sprite_bitmap_store. A behavioural model (two row
// arrays, a front index, a fill count and a sticky "armed" flag) is advanced
// at every rising edge from the same inputs the design sees; outputs are
// compared 1 time unit after the edge. Directed scenarios are followed by a
// randomized phase. Build with +define+SPRITE_STORE_CLEAR_EN to cover clear.
// -----------------------------------------------------------------------------
module tb_sprite_bitmap_store;

  localparam int ROWS = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT signals
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        frame_start = 1'b0;
  logic        rd_busy = 1'b0;
`ifdef SPRITE_STORE_CLEAR_EN
  logic        clear = 1'b0;
`endif
  logic [3:0]  rom_addr = '0;
  logic        wr_ready;
  logic [15:0] rom_bits;
  logic        bank_sel;
  logic        swap_pending;
  logic [1:0]  state_dbg;

  always #10 clk = ~clk;

  sprite_bitmap_store #(
    .DATA_W(16),
    .ADDR_W(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .frame_start  (frame_start),
    .rd_busy      (rd_busy),
`ifdef SPRITE_STORE_CLEAR_EN
    .clear        (clear),
`endif
    .rom_addr     (rom_addr),
    .rom_bits     (rom_bits),
    .bank_sel     (bank_sel),
    .swap_pending (swap_pending),
    .state_dbg    (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  logic [15:0] m_bank [2][ROWS];
  bit          m_sel = 1'b0;      // front bank index
  logic [3:0]  m_rows = '0;       // rows loaded into back bank so far
  bit          m_full = 1'b0;     // back bank complete, waiting for swap
  bit          m_armed = 1'b0;    // frame boundary seen while full
  int          m_clearing = 0;    // remaining blanking cycles

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    bit clr_in;
`ifdef SPRITE_STORE_CLEAR_EN
    clr_in = clear;
`else
    clr_in = 1'b0;
`endif
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        m_bank[0][r[3:0]] = '0;
        m_bank[1][r[3:0]] = '0;
      end
      m_sel = 1'b0; m_rows = '0; m_full = 1'b0; m_armed = 1'b0; m_clearing = 0;
    end else if (m_clearing > 0) begin
      m_clearing--;
      if (m_clearing == 0) begin
        for (int r = 0; r < ROWS; r++) m_bank[!m_sel][r[3:0]] = '0;
        m_full = 1'b1;
      end
    end else if (!m_full) begin
      if (clr_in) begin
        m_clearing = ROWS;
        m_rows = '0;
      end else if (wr_valid) begin
        m_bank[!m_sel][m_rows] = wr_data;
        if (m_rows == 4'd15) m_full = 1'b1;
        m_rows = m_rows + 4'd1;
      end
    end else begin
      if (m_armed && !rd_busy) begin
        m_sel = !m_sel;
        m_armed = 1'b0;
        m_full = 1'b0;
      end else if (frame_start) begin
        m_armed = 1'b1;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One clock: model follows the edge, outputs compared just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("wr_ready", wr_ready, (!m_full && m_clearing == 0));
    check("swap_pending", swap_pending, m_full);
    check("bank_sel", bank_sel, m_sel);
    check("rom_bits", rom_bits, m_bank[m_sel][rom_addr]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_row(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic push_front_model();
    for (int a = 0; a < ROWS; a++) exp_q.push_back(m_bank[m_sel][a[3:0]]);
  endtask

  // Walk rom_addr over every row between two edges, popping expectations.
  // Must be called right after step() so the 16 x 1 unit sweep fits the cycle.
  task automatic sweep(input string tag);
    for (int a = 0; a < ROWS; a++) begin
      rom_addr = a[3:0];
      #1;
      if (exp_q.size() == 0) check({tag, "_qempty"}, 1, 0);
      else check(tag, rom_bits, exp_q.pop_front());
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] pat;
    logic [15:0] saved [ROWS];
    int          sel_before;

    // 1: reset state
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    step();
    check("t1_wr_ready", wr_ready, 1);
    check("t1_bank_sel", bank_sel, 0);
    for (int a = 0; a < ROWS; a++) exp_q.push_back(16'h0000);
    sweep("t1_rom_zero");

    // 2: full load, swap at next frame with renderer idle
    for (int r = 0; r < ROWS; r++) begin
      pat = 16'h0101;
      pat = (pat << r) | (pat >> (16 - r));
      write_row(pat);
    end
    check("t2_pending", swap_pending, 1);
    pulse_frame();
    check("t2_pending_armed", swap_pending, 1);
    step();
    check("t2_swapped", swap_pending, 0);
    check("t2_bank_sel", bank_sel, 1);
    rom_addr = 4'd3;
    #1;
    check("t2_row3", rom_bits, 16'h0808);
    push_front_model();
    sweep("t2_front");

    // 3: partial bank ignores frame_start; busy renderer defers swap
    for (int r = 0; r < 15; r++) write_row(16'(32'hA5A5 ^ r));
    pulse_frame();
    check("t3_partial_ready", wr_ready, 1);
    check("t3_partial_nopend", swap_pending, 0);
    write_row(16'h5A5A);
    sel_before = int'(m_sel);
    rd_busy = 1'b1;
    pulse_frame();
    for (int i = 0; i < 20; i++) begin
      step();
      check("t3_busy_hold", bank_sel, sel_before);
    end
    rd_busy = 1'b0;
    step();
    check("t3_flip_after_busy", bank_sel, 1 - sel_before);

    // 4: last row accepted together with frame_start does not arm
    for (int r = 0; r < 15; r++) write_row(16'($urandom));
    sel_before = int'(m_sel);
    frame_start = 1'b1;
    write_row(16'hC3C3);
    frame_start = 1'b0;
    idle(3);
    check("t4_pending", swap_pending, 1);
    check("t4_no_swap", bank_sel, sel_before);
    pulse_frame();
    step();
    check("t4_swap", bank_sel, 1 - sel_before);

    // 5: writes during PENDING are refused and leave the back bank intact
    for (int r = 0; r < ROWS; r++) begin
      saved[r] = 16'($urandom);
      write_row(saved[r]);
    end
    wr_valid = 1'b1;
    wr_data  = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_not_ready", wr_ready, 0);
    end
    wr_valid = 1'b0;
    pulse_frame();
    step();
    for (int r = 0; r < ROWS; r++) exp_q.push_back(saved[r]);
    sweep("t5_back_intact");

`ifdef SPRITE_STORE_CLEAR_EN
    // 6: clear blanks the back bank and queues it
    for (int r = 0; r < ROWS; r++) write_row(16'hFFFF);
    pulse_frame();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      step();
      check("t6_clear_busy", wr_ready, 0);
    end
    check("t6_clear_pending", swap_pending, 1);
    pulse_frame();
    step();
    for (int a = 0; a < ROWS; a++) exp_q.push_back(16'h0000);
    sweep("t6_blank");
    // reset in the middle of a clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    idle(7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("t6_rst_ready", wr_ready, 1);
    check("t6_rst_pending", swap_pending, 0);
    check("t6_rst_sel", bank_sel, 0);
    for (int a = 0; a < ROWS; a++) exp_q.push_back(16'h0000);
    sweep("t6_rst_zero");
`endif

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      wr_valid    = ($urandom_range(0, 3) != 0);
      wr_data     = 16'($urandom);
      frame_start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) rd_busy = ~rd_busy;
      rom_addr    = 4'($urandom_range(0, 15));
      reset       = ($urandom_range(0, 199) == 0);
`ifdef SPRITE_STORE_CLEAR_EN
      clear       = ($urandom_range(0, 39) == 0);
`endif
      step();
      if ((i % 37) == 0) begin
        push_front_model();
        sweep("rand_front");
      end
    end
    wr_valid = 1'b0; frame_start = 1'b0; reset = 1'b0;
`ifdef SPRITE_STORE_CLEAR_EN
    clear = 1'b0;
`endif
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
